wb_mem_responder: RTL

//  Pipelined Wishbone B4 responder backed by on-chip RAM. It has the same user-port contract as the DDR3 controller:

---
 rtl/wb_mem_responder.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/wb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : wb_mem_responder
// Purpose  : Pipelined Wishbone B4 RAM responder with DDR3-like stall timing.
// Revision : 1.0  initial release
// ============================================================================
module wb_mem_responder #(
  parameter int ADDR_BITS        = 8,
  parameter int DATA_BITS        = 8,
  parameter int AUX_WIDTH        = 16,
  parameter int LATENCY          = 3,
  parameter int INIT_CYCLES      = 16,
  parameter int REFRESH_INTERVAL = 64,
  parameter int REFRESH_CYCLES   = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_wb_cyc,
  input  logic                   i_wb_stb,
  input  logic                   i_wb_we,
  input  logic [ADDR_BITS-1:0]   i_wb_addr,
  input  logic [DATA_BITS-1:0]   i_wb_data,
  input  logic [DATA_BITS/8-1:0] i_wb_sel,
  input  logic [AUX_WIDTH-1:0]   i_aux,
  output logic                   o_wb_stall,
  output logic                   o_wb_ack,
  output logic [DATA_BITS-1:0]   o_wb_data,
  output logic [AUX_WIDTH-1:0]   o_aux,
  output logic                   o_init_done
);

  localparam int SEL_BITS = DATA_BITS / 8;
  localparam int INIT_W   = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam int REF_MAX  = (REFRESH_INTERVAL > 0) ? REFRESH_INTERVAL - 1 : 0;
  localparam int REF_W    = (REF_MAX > 0) ? $clog2(REF_MAX + 1) : 1;
  localparam int RCYC_W   = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  localparam logic [INIT_W-1:0] INIT_LAST  = INIT_W'(INIT_CYCLES - 1);
  localparam logic [REF_W-1:0]  REF_RELOAD = REF_W'(REF_MAX);
  localparam logic [RCYC_W-1:0] RCYC_LAST  = RCYC_W'(REFRESH_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_RUN     = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_REFRESH = 2'd3
  } state_t;

  state_t              state;
  logic [INIT_W-1:0]   init_cnt;
  logic [REF_W-1:0]    ref_cnt;
  logic [RCYC_W-1:0]   rcyc_cnt;

  logic [DATA_BITS-1:0] mem [2**ADDR_BITS];

  logic [LATENCY-1:0]   pipe_valid;
  logic [DATA_BITS-1:0] pipe_data [LATENCY];
  logic [AUX_WIDTH-1:0] pipe_aux  [LATENCY];

  logic                 accept;
  logic                 drained;
  logic [LATENCY-1:0]   valid_after;

  assign accept      = i_wb_cyc & i_wb_stb & ~o_wb_stall & ~i_rst;
  // Occupancy the pipeline will have after this edge; the last stage leaves as an ack.
  assign valid_after = pipe_valid << 1;
  assign drained     = ~i_wb_cyc | (valid_after == '0);

  always_ff @(posedge i_clk) begin
    if (accept && i_wb_we) begin
      for (int b = 0; b < SEL_BITS; b++) begin
        if (i_wb_sel[b]) mem[i_wb_addr][b*8 +: 8] <= i_wb_data[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    pipe_data[0] <= i_wb_we ? '0 : mem[i_wb_addr];
    pipe_aux[0]  <= i_aux;
    for (int s = 1; s < LATENCY; s++) begin
      pipe_data[s] <= pipe_data[s-1];
      pipe_aux[s]  <= pipe_aux[s-1];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pipe_valid <= '0;
      o_wb_ack   <= 1'b0;
      o_wb_data  <= '0;
      o_aux      <= '0;
    end else begin
      // A low cyc kills every in-flight entry, including the one about to ack.
      pipe_valid <= i_wb_cyc ? (valid_after | LATENCY'(accept)) : '0;
      o_wb_ack   <= i_wb_cyc & pipe_valid[LATENCY-1];
      if (i_wb_cyc && pipe_valid[LATENCY-1]) begin
        o_wb_data <= pipe_data[LATENCY-1];
        o_aux     <= pipe_aux[LATENCY-1];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= ST_INIT;
      o_wb_stall  <= 1'b1;
      o_init_done <= 1'b0;
      init_cnt    <= '0;
      ref_cnt     <= REF_RELOAD;
      rcyc_cnt    <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          if (init_cnt == INIT_LAST) begin
            state       <= ST_RUN;
            o_wb_stall  <= 1'b0;
            o_init_done <= 1'b1;
          end else begin
            init_cnt <= init_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (REFRESH_INTERVAL != 0 && ref_cnt == '0) begin
            state      <= ST_DRAIN;
            o_wb_stall <= 1'b1;
            ref_cnt    <= REF_RELOAD;
          end else begin
            ref_cnt <= ref_cnt - 1'b1;
          end
        end
        ST_DRAIN: begin
          if (drained) begin
            state    <= ST_REFRESH;
            rcyc_cnt <= '0;
          end
        end
        ST_REFRESH: begin
          if (rcyc_cnt == RCYC_LAST) begin
            state      <= ST_RUN;
            o_wb_stall <= 1'b0;
          end else begin
            rcyc_cnt <= rcyc_cnt + 1'b1;
          end
        end
        default: begin
          state      <= ST_INIT;
          o_wb_stall <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
